// File: rtl/write_txn_track_table.sv
// Write-transaction tracker: AW pass-through with a pending (id, len) FIFO feeding a
// DEPTH-slot interleave table retired by W handshakes. Optional beat checking: WR_TRACK_BEAT_CHECK_EN.
module write_txn_track_table #(
  parameter int ADDR_W     = 12,
  parameter int ID_W       = 6,
  parameter int DEPTH      = 3,
  parameter int FIFO_DEPTH = 8,
  parameter int INTERLEAVE = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_W-1:0]                  s_awaddr,
  input  logic [7:0]                         s_awlen,
  input  logic [2:0]                         s_awsize,
  input  logic [1:0]                         s_awburst,
  input  logic [ID_W-1:0]                    s_awid,
  input  logic                               s_awvalid,
  output logic                               s_awready,
  output logic [ADDR_W-1:0]                  m_awaddr,
  output logic [7:0]                         m_awlen,
  output logic [2:0]                         m_awsize,
  output logic [1:0]                         m_awburst,
  output logic [ID_W-1:0]                    m_awid,
  output logic                               m_awvalid,
  input  logic                               m_awready,
  input  logic                               w_valid,
  input  logic                               w_ready,
  input  logic                               w_last,
  input  logic [ID_W-1:0]                    w_id,
  output logic [DEPTH-1:0]                   slot_valid,
  output logic [DEPTH-1:0]                   slot_active,
  output logic [DEPTH*ID_W-1:0]              slot_id,
  output logic [DEPTH*8-1:0]                 slot_len,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               unmatched_err,
  output logic                               beat_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SLT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = ID_W + 8;

  logic [ENT_W-1:0]             fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr_r;
  logic [PTR_W-1:0]             rd_ptr_r;
  logic [CNT_W-1:0]             count_r;
  logic                         full_s;
  logic                         empty_s;
  logic                         push_s;
  logic                         pop_s;
  logic [ID_W-1:0]              head_id_s;
  logic [7:0]                   head_len_s;

  logic [DEPTH-1:0]             slot_valid_r;
  logic [DEPTH-1:0]             slot_active_r;
  logic [DEPTH-1:0][ID_W-1:0]   slot_id_r;
  logic [DEPTH-1:0][7:0]        slot_len_r;
  logic                         unmatched_err_r;

  logic                         free_any_s;
  logic [SLT_W-1:0]             free_idx_s;
  logic                         id_clash_s;
  logic                         interleave_ok_s;
  logic [DEPTH-1:0]             hit_s;
  logic                         beat_s;
  logic                         match_s;

  // Ready/valid gating uses the registered count, so a same-cycle pop never opens a full FIFO.
  assign full_s     = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s    = (count_r == {CNT_W{1'b0}});
  assign m_awaddr   = s_awaddr;
  assign m_awlen    = s_awlen;
  assign m_awsize   = s_awsize;
  assign m_awburst  = s_awburst;
  assign m_awid     = s_awid;
  assign m_awvalid  = s_awvalid & ~full_s;
  assign s_awready  = m_awready & ~full_s;
  assign push_s     = s_awvalid & s_awready;
  assign head_id_s  = fifo_mem_r[rd_ptr_r][ID_W-1:0];
  assign head_len_s = fifo_mem_r[rd_ptr_r][ENT_W-1:ID_W];

  assign beat_s  = w_valid & w_ready;
  assign match_s = beat_s & (|hit_s);

  // Slot scan: lowest free slot, head-ID conflict and W-ID match, all from start-of-cycle state.
  always_comb begin
    free_any_s = 1'b0;
    free_idx_s = {SLT_W{1'b0}};
    id_clash_s = 1'b0;
    hit_s      = {DEPTH{1'b0}};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      free_any_s = free_any_s | ~slot_valid_r[k];
      id_clash_s = id_clash_s | (slot_valid_r[k] & (slot_id_r[k] == head_id_s));
      hit_s[k]   = slot_valid_r[k] & (slot_id_r[k] == w_id);
      if (!slot_valid_r[k]) begin
        free_idx_s = SLT_W'(k);
      end else begin
        free_idx_s = free_idx_s;
      end
    end
  end

  // Admission rule: non-empty queue, a free slot, no same-ID slot, and serial mode needs an empty table.
  always_comb begin
    if (INTERLEAVE != 0) begin
      interleave_ok_s = 1'b1;
    end else begin
      interleave_ok_s = (slot_valid_r == {DEPTH{1'b0}});
    end
    pop_s = ~empty_s & free_any_s & ~id_clash_s & interleave_ok_s;
  end

  // Pending-entry storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= {s_awlen, s_awid};
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Slot table: W beats retire the matching slot, a pop fills the chosen free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_r    <= {DEPTH{1'b0}};
      slot_active_r   <= {DEPTH{1'b0}};
      slot_id_r       <= '0;
      slot_len_r      <= '0;
      unmatched_err_r <= 1'b0;
    end else begin
      unmatched_err_r <= beat_s & ~(|hit_s);
      for (int k = 0; k < DEPTH; k++) begin
        if (beat_s && hit_s[k]) begin
          if (w_last) begin
            slot_valid_r[k]  <= 1'b0;
            slot_active_r[k] <= 1'b0;
          end else begin
            slot_active_r[k] <= 1'b1;
          end
        end
        // The allocated slot was free at cycle start, so it never collides with a retiring one.
        if (pop_s && (free_idx_s == SLT_W'(k))) begin
          slot_valid_r[k]  <= 1'b1;
          slot_active_r[k] <= 1'b0;
          slot_id_r[k]     <= head_id_s;
          slot_len_r[k]    <= head_len_s;
        end
      end
    end
  end

  assign slot_valid    = slot_valid_r;
  assign slot_active   = slot_active_r;
  assign slot_id       = slot_id_r;
  assign slot_len      = slot_len_r;
  assign fifo_count    = count_r;
  assign unmatched_err = unmatched_err_r;

`ifdef WR_TRACK_BEAT_CHECK_EN
  logic [DEPTH-1:0][7:0] rem_r;
  logic [7:0]            hit_rem_s;
  logic                  beat_err_r;

  // Remaining-beat count of the slot hit by the current W beat.
  always_comb begin
    hit_rem_s = 8'h00;
    for (int k = 0; k < DEPTH; k++) begin
      hit_rem_s = hit_rem_s | (hit_s[k] ? rem_r[k] : 8'h00);
    end
  end

  // Per-slot beat counters; an over-long burst sticks at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_r      <= '0;
      beat_err_r <= 1'b0;
    end else begin
      beat_err_r <= match_s & (w_last ? (hit_rem_s != 8'h00) : (hit_rem_s == 8'h00));
      for (int k = 0; k < DEPTH; k++) begin
        if (pop_s && (free_idx_s == SLT_W'(k))) begin
          rem_r[k] <= head_len_s;
        end else if (beat_s && hit_s[k] && !w_last && (rem_r[k] != 8'h00)) begin
          rem_r[k] <= rem_r[k] - 8'h01;
        end else begin
          rem_r[k] <= rem_r[k];
        end
      end
    end
  end

  assign beat_err = beat_err_r;
`else
  assign beat_err = 1'b0;
`endif

endmodule

// File: tb/tb_write_txn_track_table.sv
// Directed bench for write_txn_track_table: vector tables for the main flows plus hand
// sequences for FIFO-full, mid-burst reset and beat checking (WR_TRACK_BEAT_CHECK_EN aware).
module tb_write_txn_track_table;

  typedef struct {
    logic       aw_v;
    logic [5:0] aw_id;
    logic [7:0] aw_len;
    logic       w_v;
    logic       w_r;
    logic       w_l;
    logic [5:0] w_id;
    logic [2:0] e_sv;
    logic [2:0] e_sa;
    logic [3:0] e_cnt;
    logic       e_um;
  } vec_t;

`ifdef WR_TRACK_BEAT_CHECK_EN
  localparam logic EXP_BE = 1'b1;
`else
  localparam logic EXP_BE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  // main DUT (INTERLEAVE=1)
  logic [11:0] s_awaddr = 12'h000, m_awaddr;
  logic [7:0]  s_awlen = 8'd0, m_awlen;
  logic [2:0]  s_awsize = 3'd2, m_awsize;
  logic [1:0]  s_awburst = 2'd1, m_awburst;
  logic [5:0]  s_awid = 6'd0, m_awid;
  logic        s_awvalid = 1'b0, s_awready, m_awvalid, m_awready = 1'b1;
  logic        w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
  logic [5:0]  w_id = 6'd0;
  logic [2:0]  slot_valid, slot_active;
  logic [17:0] slot_id;
  logic [23:0] slot_len;
  logic [3:0]  fifo_count;
  logic        unmatched_err, beat_err;

  // second DUT (INTERLEAVE=0)
  logic [11:0] i_m_awaddr;
  logic [7:0]  i_awlen = 8'd0, i_m_awlen;
  logic [2:0]  i_m_awsize;
  logic [1:0]  i_m_awburst;
  logic [5:0]  i_awid = 6'd0, i_m_awid;
  logic        i_awvalid = 1'b0, i_awready, i_m_awvalid;
  logic        i_w_valid = 1'b0, i_w_ready = 1'b0, i_w_last = 1'b0;
  logic [5:0]  i_w_id = 6'd0;
  logic [2:0]  i_slot_valid, i_slot_active;
  logic [17:0] i_slot_id;
  logic [23:0] i_slot_len;
  logic [3:0]  i_fifo_count;
  logic        i_unmatched_err, i_beat_err;

  write_txn_track_table dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awid(s_awid), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_id(w_id),
    .slot_valid(slot_valid), .slot_active(slot_active), .slot_id(slot_id), .slot_len(slot_len),
    .fifo_count(fifo_count), .unmatched_err(unmatched_err), .beat_err(beat_err)
  );

  write_txn_track_table #(.INTERLEAVE(0)) dut_serial (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awlen(i_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_awid(i_awid), .s_awvalid(i_awvalid), .s_awready(i_awready),
    .m_awaddr(i_m_awaddr), .m_awlen(i_m_awlen), .m_awsize(i_m_awsize), .m_awburst(i_m_awburst),
    .m_awid(i_m_awid), .m_awvalid(i_m_awvalid), .m_awready(1'b1),
    .w_valid(i_w_valid), .w_ready(i_w_ready), .w_last(i_w_last), .w_id(i_w_id),
    .slot_valid(i_slot_valid), .slot_active(i_slot_active), .slot_id(i_slot_id),
    .slot_len(i_slot_len), .fifo_count(i_fifo_count), .unmatched_err(i_unmatched_err),
    .beat_err(i_beat_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic av, input logic [5:0] aid, input logic [7:0] alen,
                              input logic wv, input logic wr, input logic wl, input logic [5:0] wid,
                              input logic [2:0] sv, input logic [2:0] sa, input logic [3:0] cnt,
                              input logic um);
    vec_t v;
    v.aw_v = av; v.aw_id = aid; v.aw_len = alen;
    v.w_v = wv; v.w_r = wr; v.w_l = wl; v.w_id = wid;
    v.e_sv = sv; v.e_sa = sa; v.e_cnt = cnt; v.e_um = um;
    return v;
  endfunction

  // Drive one row at the falling edge, then check state left by earlier rows.
  task automatic apply(input vec_t v, input int d, input int idx);
    @(negedge clk);
    if (d == 0) begin
      s_awvalid = v.aw_v; s_awid = v.aw_id; s_awlen = v.aw_len;
      w_valid = v.w_v; w_ready = v.w_r; w_last = v.w_l; w_id = v.w_id;
    end else begin
      i_awvalid = v.aw_v; i_awid = v.aw_id; i_awlen = v.aw_len;
      i_w_valid = v.w_v; i_w_ready = v.w_r; i_w_last = v.w_l; i_w_id = v.w_id;
    end
    #1;
    if (d == 0) begin
      chk($sformatf("d0_r%0d_slot_valid", idx), 32'(slot_valid), 32'(v.e_sv));
      chk($sformatf("d0_r%0d_slot_active", idx), 32'(slot_active), 32'(v.e_sa));
      chk($sformatf("d0_r%0d_fifo_count", idx), 32'(fifo_count), 32'(v.e_cnt));
      chk($sformatf("d0_r%0d_unmatched", idx), 32'(unmatched_err), 32'(v.e_um));
      chk($sformatf("d0_r%0d_beat_err", idx), 32'(beat_err), 32'd0);
      chk($sformatf("d0_r%0d_awready", idx), 32'(s_awready), 32'd1);
    end else begin
      chk($sformatf("d1_r%0d_slot_valid", idx), 32'(i_slot_valid), 32'(v.e_sv));
      chk($sformatf("d1_r%0d_slot_active", idx), 32'(i_slot_active), 32'(v.e_sa));
      chk($sformatf("d1_r%0d_fifo_count", idx), 32'(i_fifo_count), 32'(v.e_cnt));
      chk($sformatf("d1_r%0d_unmatched", idx), 32'(i_unmatched_err), 32'(v.e_um));
    end
  endtask

  task automatic set_w(input logic v, input logic l, input logic [5:0] id);
    w_valid = v; w_ready = v; w_last = l; w_id = id;
  endtask

  vec_t tab_main[$];
  vec_t tab_serial[$];
  int   acc;

  initial begin
    // single burst id5 len3, then unmatched beat id9
    tab_main.push_back(mk(1, 5, 3, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 5, 3'b001, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 5, 3'b001, 3'b001, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 5, 3'b001, 3'b001, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 1, 5, 3'b001, 3'b001, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 9, 3'b000, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 1));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    // ids 1..4 back-to-back, len1; id4 waits for id2 to retire; w_last without w_ready on row 14
    tab_main.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    tab_main.push_back(mk(1, 2, 1, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0));
    tab_main.push_back(mk(1, 3, 1, 0, 0, 0, 0, 3'b001, 3'b000, 1, 0));
    tab_main.push_back(mk(1, 4, 1, 0, 0, 0, 0, 3'b011, 3'b000, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 0, 1, 1, 3'b111, 3'b000, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 2, 3'b111, 3'b000, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 1, 2, 3'b111, 3'b010, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b101, 3'b000, 1, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b111, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 1, 3'b111, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 1, 1, 3'b111, 3'b001, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 3, 3'b110, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 1, 3, 3'b110, 3'b100, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 0, 4, 3'b010, 3'b000, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 1, 1, 1, 4, 3'b010, 3'b010, 0, 0));
    tab_main.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    // serial mode: id7, id7, id8 admitted strictly one at a time
    tab_serial.push_back(mk(1, 7, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));
    tab_serial.push_back(mk(1, 7, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0));
    tab_serial.push_back(mk(1, 8, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1, 0));
    tab_serial.push_back(mk(0, 0, 0, 1, 1, 1, 7, 3'b001, 3'b000, 2, 0));
    tab_serial.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2, 0));
    tab_serial.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1, 0));
    tab_serial.push_back(mk(0, 0, 0, 1, 1, 1, 7, 3'b001, 3'b000, 1, 0));
    tab_serial.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 1, 0));
    tab_serial.push_back(mk(0, 0, 0, 1, 1, 1, 8, 3'b001, 3'b000, 0, 0));
    tab_serial.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0, 0));

    // reset state and combinational AW pass-through
    s_awaddr = 12'hABC; s_awid = 6'd33; s_awlen = 8'd17;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_slot_valid", 32'(slot_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_awready", 32'(s_awready), 32'd1);
    chk("rst_slot_id", 32'(slot_id), 32'd0);
    chk("rst_slot_len", 32'(slot_len), 32'd0);
    chk("pass_awaddr", 32'(m_awaddr), 32'h0ABC);
    chk("pass_awid_len", {16'd0, m_awlen, 2'd0, m_awid}, {16'd0, 8'd17, 2'd0, 6'd33});
    chk("pass_size_burst", 32'({m_awsize, m_awburst}), 32'({3'd2, 2'd1}));
    rst_n = 1'b1;
    s_awid = 6'd0; s_awlen = 8'd0;

    for (int i = 0; i < tab_main.size(); i++) begin
      apply(tab_main[i], 0, i);
      if (i == 2) begin
        chk("burst_slot_len0", 32'(slot_len[7:0]), 32'd3);
        chk("burst_slot_id0", 32'(slot_id[5:0]), 32'd5);
      end
      if (i == 19) begin
        chk("quad_slot_ids", 32'(slot_id), 32'((3 << 12) | (4 << 6) | 1));
        chk("quad_slot_lens", 32'(slot_len), 32'h010101);
      end
    end
    for (int i = 0; i < tab_serial.size(); i++) begin
      apply(tab_serial[i], 1, i);
    end

    // fill: 3 slots + 8 queued entries, then the FIFO stalls
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      s_awid = 6'(10 + acc); s_awlen = 8'd0; s_awvalid = 1'b1;
      set_w(1'b0, 1'b0, 6'd0);
      #1;
      if (!s_awready) break;
      acc++;
    end
    chk("full_accepts", 32'(acc), 32'd11);
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_m_awvalid", 32'(m_awvalid), 32'd0);
    chk("full_slot_valid", 32'(slot_valid), 32'd7);
    @(negedge clk);
    set_w(1'b1, 1'b1, 6'd10);
    #1;
    chk("full_ready_before_retire", 32'(s_awready), 32'd0);
    @(negedge clk);
    set_w(1'b0, 1'b0, 6'd0);
    #1;
    chk("full_ready_during_pop", 32'(s_awready), 32'd0);
    chk("full_retired", 32'(slot_valid), 32'd6);
    @(negedge clk);
    s_awvalid = 1'b0;
    #1;
    chk("full_ready_after_pop", 32'(s_awready), 32'd1);
    chk("full_count_after_pop", 32'(fifo_count), 32'd7);
    chk("full_refill_id", 32'(slot_id[5:0]), 32'd13);

    // mid-burst reset
    @(negedge clk);
    set_w(1'b1, 1'b0, 6'd11);
    @(negedge clk);
    set_w(1'b0, 1'b0, 6'd0);
    rst_n = 1'b0;
    #1;
    chk("midburst_active", 32'(slot_active), 32'd2);
    @(negedge clk);
    m_awready = 1'b0;
    #1;
    chk("mrst_slot_valid", 32'(slot_valid), 32'd0);
    chk("mrst_slot_active", 32'(slot_active), 32'd0);
    chk("mrst_slot_id", 32'(slot_id), 32'd0);
    chk("mrst_slot_len", 32'(slot_len), 32'd0);
    chk("mrst_fifo_count", 32'(fifo_count), 32'd0);
    chk("mrst_errs", 32'({unmatched_err, beat_err}), 32'd0);
    chk("mrst_ready_follows_lo", 32'(s_awready), 32'd0);
    m_awready = 1'b1;
    #1;
    chk("mrst_ready_follows_hi", 32'(s_awready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // short burst: len3 but w_last on beat 2
    @(negedge clk);
    s_awvalid = 1'b1; s_awid = 6'd5; s_awlen = 8'd3;
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    set_w(1'b1, 1'b0, 6'd5);
    #1;
    chk("short_slot_valid", 32'(slot_valid), 32'd1);
    @(negedge clk);
    set_w(1'b1, 1'b1, 6'd5);
    #1;
    chk("short_no_err_beat1", 32'(beat_err), 32'd0);
    @(negedge clk);
    set_w(1'b0, 1'b0, 6'd0);
    #1;
    chk("short_beat_err", 32'(beat_err), 32'(EXP_BE));
    chk("short_freed", 32'(slot_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("short_err_one_cycle", 32'(beat_err), 32'd0);

    // long burst: len0 but a non-last beat
    @(negedge clk);
    s_awvalid = 1'b1; s_awid = 6'd6; s_awlen = 8'd0;
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    set_w(1'b1, 1'b0, 6'd6);
    @(negedge clk);
    set_w(1'b1, 1'b1, 6'd6);
    #1;
    chk("long_beat_err", 32'(beat_err), 32'(EXP_BE));
    @(negedge clk);
    set_w(1'b0, 1'b0, 6'd0);
    #1;
    chk("long_freed", 32'(slot_valid), 32'd0);
    chk("long_no_unmatched", 32'(unmatched_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/write_txn_track_table.md
# write_txn_track_table

Parametrised write-transaction tracker for the crossbar slave-side write path. It sits between the write-address arbiter and the slave port:
- passes AW through with FIFO back-pressure;
- queues accepted (id, len) pairs;
- admits them into a DEPTH-slot interleave table under AXI3 same-ID ordering rules;
- retires slots from W-channel handshakes.

The slot table feeds the write-data arbiter. Compared with the fixed 3-slot generation, it generalises ID width, slot count and FIFO depth, qualifies retirement with the W handshake, and adds per-slot beat counting plus error reporting.

## Interface
Parameters:
- ADDR_W, 12, AW address width
- ID_W, 6, transaction ID width
- DEPTH, 3, interleave slots (1..8)
- FIFO_DEPTH, 8, queued AW entries awaiting slot admission (power of two, ≥2)
- INTERLEAVE, 1, 1 = up to DEPTH distinct IDs outstanding; 0 = one slot at a time

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous active-low
- s_awaddr/s_awlen/s_awsize/s_awburst/s_awid  in  ADDR_W/8/3/2/ID_W  AW from arbiter
- s_awvalid  in  1;  s_awready  out  1
- m_awaddr/m_awlen/m_awsize/m_awburst/m_awid  out  same widths  AW to slave, combinational copy of s_aw*
- m_awvalid  out  1;  m_awready  in  1
- w_valid, w_ready, w_last  in  1 each  W channel as driven to slave
- w_id  in  ID_W  W channel ID
- slot_valid  out  DEPTH  slot holds an outstanding transaction
- slot_active  out  DEPTH  slot has accepted ≥1 beat
- slot_id  out  DEPTH*ID_W  slot k at [k*ID_W +: ID_W]
- slot_len  out  DEPTH*8  awlen of slot k
- fifo_count  out  $clog2(FIFO_DEPTH+1)  queued entries
- unmatched_err  out  1  one-cycle pulse
- beat_err  out  1  one-cycle pulse (see Configuration)

## Operation
- Gating: full = (fifo_count == FIFO_DEPTH).
  - m_awvalid = s_awvalid & !full.
  - s_awready = m_awready & !full.
  - Push occurs on s_awvalid & s_awready; payload is {awlen, awid}.
- Admission: pop occurs when all of the following hold:
  - FIFO is non-empty;
  - at least one slot is free;
  - no valid slot has slot_id == head id;
  - if INTERLEAVE=0, no slot is valid.
- Allocation:
  - The popped entry goes to the lowest-index free slot, sampled at the start of the cycle.
  - A slot freed in the same cycle is not reusable until the next cycle.
  - The slot's remaining-beat counter is loaded with len.
- W matching:
  - A beat is a cycle with w_valid & w_ready.
  - It matches the valid slot whose slot_id == w_id. IDs are unique by construction.
  - On match: slot_active is set and the counter is decremented.
  - On match with w_last: slot_valid and slot_active are cleared.
  - A beat with no matching slot pulses unmatched_err and changes no state.
  - w_last without a handshake has no effect.
- Simultaneous events: allocation into slot a and retirement of slot b (a≠b) in one cycle both take effect. Push and pop in one cycle leave fifo_count unchanged.
- Reset (rst_n low at an edge, including mid-burst):
  - FIFO is emptied; fifo_count = 0.
  - slot_valid = 0 and slot_active = 0.
  - slot_id and slot_len = 0; counters = 0.
  - unmatched_err = 0 and beat_err = 0.
  - m_aw* follow their inputs combinationally; s_awready = m_awready, because the FIFO is empty.

## Timing
- AW path has zero latency (combinational).
- AW handshake in cycle N → entry poppable in N+1 → slot_valid visible from N+2 at the earliest.
- Retirement: the final beat in cycle M → slot_valid low from M+1.
- Error pulses are registered: one cycle, asserted in the cycle after the offending beat.
- Full FIFO: s_awready stays low until a pop. A pop in the same cycle does not raise s_awready (ready is computed from registered count).

## Configuration
- WR_TRACK_BEAT_CHECK_EN defined:
  - Each slot keeps an 8-bit remaining-beat counter.
  - beat_err pulses if w_last arrives with remaining ≠ 0.
  - beat_err also pulses if a non-last beat arrives with remaining == 0.
  - On w_last the slot is retired regardless.
- Undefined: counters are not built and beat_err is tied 0. All other behaviour is identical.

## Test plan
- Reset, then AW id=5 len=3 accepted at N, four beats with w_last on the 4th → slot_valid[0]=1 at N+2, slot_len0=3; cleared the cycle after the last beat; no error pulses.
- DEPTH=3, INTERLEAVE=1, AW ids 1,2,3,4 back-to-back → slots 0..2 hold 1,2,3; id 4 stays queued (fifo_count=1) until id 2 retires, then takes slot 1.
- AW id=7 twice, INTERLEAVE=0 → second entry is not admitted until the first slot retires; slot_valid never exceeds one bit set.
- m_awready=1, no W traffic, FIFO_DEPTH=8, 8+3 slots' worth of AW → s_awready drops after 11 accepts (3 slots + 8 queued); m_awvalid=0 while full.
- Beat with w_id=9 and no slot → unmatched_err=1 for one cycle; w_last=1 without w_ready → slot remains valid.
- With WR_TRACK_BEAT_CHECK_EN, len=3 but w_last on beat 2 → beat_err pulses once and the slot is freed; rst_n low mid-burst → all slots and counters clear at that edge.
